// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: ALU selection codes,
// FSM state encodings, iteration count and op-classification helpers.
// Ports: none (package).
package muldiv_unit_pkg;

   // ALU selection codes produced by the ALU control decoder.
   localparam logic [4:0] ALU_ADD    = 5'b00000;
   localparam logic [4:0] ALU_SUB    = 5'b00001;
   localparam logic [4:0] ALU_MUL    = 5'b10000;
   localparam logic [4:0] ALU_MULH   = 5'b10001;
   localparam logic [4:0] ALU_MULHSU = 5'b10010;
   localparam logic [4:0] ALU_MULHU  = 5'b10011;
   localparam logic [4:0] ALU_DIV    = 5'b10100;
   localparam logic [4:0] ALU_DIVU   = 5'b10101;
   localparam logic [4:0] ALU_REM    = 5'b10110;
   localparam logic [4:0] ALU_REMU   = 5'b10111;

   // One bit of product/quotient is produced per iteration.
   localparam int MD_ITERS = 32;

   typedef enum logic [1:0] {
      MDS_IDLE = 2'd0,
      MDS_BUSY = 2'd1,
      MDS_FIX  = 2'd2,
      MDS_DONE = 2'd3
   } md_state_e;

   function automatic logic is_m_op(input logic [4:0] sel);
      return (sel inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                          ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU});
   endfunction

   function automatic logic is_div_op(input logic [4:0] sel);
      return (sel inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU});
   endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One unsigned iteration step: shift-add multiply (LSB first) or restoring divide (MSB first).
// Latency: purely combinational; the caller registers hi/lo every BUSY cycle.
// Backpressure: none; stepping is gated entirely by the caller's FSM.
// Ports: is_div_i selects divide; hi_i/lo_i current accumulator (mul: product hi / multiplier-low,
//        div: partial remainder / dividend-quotient); b_i multiplicand or divisor; hi_o/lo_o next value.
module muldiv_iter_core #(
   parameter int XLEN = 32
) (
   input  logic            is_div_i,
   input  logic [XLEN-1:0] hi_i,
   input  logic [XLEN-1:0] lo_i,
   input  logic [XLEN-1:0] b_i,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o
);

   logic [XLEN:0] sum;
   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   always_comb begin
      hi_o    = hi_i;
      lo_o    = lo_i;
      // Multiply: add multiplicand when the current multiplier bit is set, then shift the
      // whole {carry, hi, lo} right; multiplier bits drain out of lo as product bits enter.
      sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
      // Divide: bring the next dividend bit into the remainder and trial-subtract.
      shifted = {hi_i, lo_i[XLEN-1]};
      diff    = shifted - {1'b0, b_i};
      if (is_div_i) begin
         // Borrow out of the extra top bit means the trial subtraction went negative.
         if (!diff[XLEN]) begin
            hi_o = diff[XLEN-1:0];
            lo_o = {lo_i[XLEN-2:0], 1'b1};
         end else begin
            hi_o = shifted[XLEN-1:0];
            lo_o = {lo_i[XLEN-2:0], 1'b0};
         end
      end else begin
         hi_o = sum[XLEN:1];
         lo_o = {sum[0], lo_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: FSM, special-case divides, sign correction around an iterative core.
// Latency: start accepted at N -> done at N+34 (N+1 for div-by-zero/overflow; N+2 for MUL* when
// MULDIV_FAST_MUL_EN is defined). Backpressure: busy stalls the pipe; start ignored unless IDLE.
// Ports: clk/rst (sync, active-high); start/alu_sel/op_a/op_b request; flush aborts;
//        busy stall request; done one-cycle pulse; result registered, held until next accept.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [4:0]      alu_sel,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CNT_W = $clog2(MD_ITERS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_ITERS - 1);
   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   md_state_e       state_q, state_d;
   logic [4:0]      op_q, op_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] b_q, b_d;
   logic            neg_q, neg_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [XLEN-1:0] result_q, result_d;

   logic            neg_a, neg_b;
   logic [XLEN-1:0] mag_a, mag_b;
   logic            div_zero, div_ovf;
   logic [XLEN-1:0] core_hi, core_lo;
   logic [2*XLEN-1:0] prod_u, prod_s;
   logic [XLEN-1:0] quo_s, rem_s, fix_res;

   // Operand signs only matter for the signed forms; MULHSU treats op_b as unsigned.
   assign neg_a    = op_a[XLEN-1] && (alu_sel inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM});
   assign neg_b    = op_b[XLEN-1] && (alu_sel inside {ALU_MULH, ALU_DIV, ALU_REM});
   assign mag_a    = neg_a ? -op_a : op_a;
   assign mag_b    = neg_b ? -op_b : op_b;
   assign div_zero = is_div_op(alu_sel) && (op_b == '0);
   assign div_ovf  = (alu_sel inside {ALU_DIV, ALU_REM}) && (op_a == MIN_NEG) && (op_b == '1);

   muldiv_iter_core #(.XLEN(XLEN)) u_core (
      .is_div_i (is_div_op(op_q)),
      .hi_i     (hi_q),
      .lo_i     (lo_q),
      .b_i      (b_q),
      .hi_o     (core_hi),
      .lo_o     (core_lo)
   );

   // Sign correction and word selection, evaluated in FIX.
   always_comb begin
`ifdef MULDIV_FAST_MUL_EN
      prod_u = {{XLEN{1'b0}}, lo_q} * {{XLEN{1'b0}}, b_q};
`else
      prod_u = {hi_q, lo_q};
`endif
      prod_s = neg_q ? -prod_u : prod_u;
      quo_s  = neg_q ? -lo_q : lo_q;
      rem_s  = neg_q ? -hi_q : hi_q;
      case (op_q)
         ALU_MUL:                          fix_res = prod_s[XLEN-1:0];
         ALU_MULH, ALU_MULHSU, ALU_MULHU:  fix_res = prod_s[2*XLEN-1:XLEN];
         ALU_DIV, ALU_DIVU:                fix_res = quo_s;
         default:                          fix_res = rem_s;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      b_d      = b_q;
      neg_d    = neg_q;
      count_d  = count_q;
      result_d = result_q;
      if (flush) begin
         state_d = MDS_IDLE;
      end else begin
         case (state_q)
            MDS_IDLE: begin
               if (start && is_m_op(alu_sel)) begin
                  op_d    = alu_sel;
                  hi_d    = '0;
                  lo_d    = mag_a;
                  b_d     = mag_b;
                  // Remainder takes the dividend's sign; product and quotient the XOR.
                  neg_d   = (alu_sel inside {ALU_REM, ALU_REMU}) ? neg_a : (neg_a ^ neg_b);
                  count_d = '0;
                  if (div_zero) begin
                     result_d = (alu_sel inside {ALU_DIV, ALU_DIVU}) ? '1 : op_a;
                     state_d  = MDS_DONE;
                  end else if (div_ovf) begin
                     result_d = (alu_sel == ALU_DIV) ? MIN_NEG : '0;
                     state_d  = MDS_DONE;
                  end else begin
`ifdef MULDIV_FAST_MUL_EN
                     state_d = is_div_op(alu_sel) ? MDS_BUSY : MDS_FIX;
`else
                     state_d = MDS_BUSY;
`endif
                  end
               end
            end
            MDS_BUSY: begin
               hi_d    = core_hi;
               lo_d    = core_lo;
               count_d = count_q + 1'b1;
               if (count_q == CNT_LAST) begin
                  state_d = MDS_FIX;
               end
            end
            MDS_FIX: begin
               result_d = fix_res;
               state_d  = MDS_DONE;
            end
            default: begin
               state_d = MDS_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= MDS_IDLE;
         op_q     <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         b_q      <= '0;
         neg_q    <= 1'b0;
         count_q  <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         b_q      <= b_d;
         neg_q    <= neg_d;
         count_q  <= count_d;
         result_q <= result_d;
      end
   end

   assign busy   = (state_q == MDS_BUSY) || (state_q == MDS_FIX);
   assign done   = (state_q == MDS_DONE);
   assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: hand-computed results, latency and busy-cycle checks.
// Latency: checks done at N+34 (iterative), N+1 (special divides), N+2 (fast multiply build).
// Backpressure: exercises start-in-DONE, flush abort, flush-vs-start and mid-operation reset.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT  = 2;
   localparam int MUL_BUSY = 1;
`else
   localparam int MUL_LAT  = 34;
   localparam int MUL_BUSY = 33;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [4:0]  alu_sel;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.XLEN(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .alu_sel (alu_sel),
      .op_a    (op_a),
      .op_b    (op_b),
      .flush   (flush),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one op from IDLE, wait (bounded) for done, check latency, busy cycles, result, pulse width.
   task automatic run_op(input string tag, input logic [4:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input int exp_lat, input int exp_busy);
      int lat;
      int nbusy;
      alu_sel = sel;
      op_a    = a;
      op_b    = b;
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat   = 1;
      nbusy = 0;
      while (!done && lat < 200) begin
         if (busy) nbusy++;
         @(posedge clk); #1;
         lat++;
      end
      check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check_eq({tag, "_busy"}, 32'(nbusy), 32'(exp_busy));
      check_eq({tag, "_res"}, result, exp_res);
      @(posedge clk); #1;
      check_eq({tag, "_pulse"}, {31'b0, done}, 32'd0);
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      flush   = 1'b0;
      alu_sel = ALU_ADD;
      op_a    = '0;
      op_b    = '0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_busy", {31'b0, busy}, 32'd0);
      check_eq("rst_done", {31'b0, done}, 32'd0);
      check_eq("rst_result", result, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Multiplies
      run_op("mul",    ALU_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT, MUL_BUSY);
      run_op("mulh",   ALU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT, MUL_BUSY);
      run_op("mulhu",  ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, MUL_BUSY);
      run_op("mulhsu", ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, MUL_BUSY);
      run_op("mulh_neg", ALU_MULH, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, MUL_LAT, MUL_BUSY);

      // Normal divides
      run_op("div",  ALU_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, 33);
      run_op("rem",  ALU_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, 33);
      run_op("divu", ALU_DIVU, 32'd7,        32'd2, 32'd3,        34, 33);
      run_op("remu", ALU_REMU, 32'd7,        32'd2, 32'd1,        34, 33);
      run_op("divu_big", ALU_DIVU, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF, 34, 33);

      // Special divides: immediate result, no busy
      run_op("div0",    ALU_DIV,  32'd5,        32'd0,        32'hFFFFFFFF, 1, 0);
      run_op("divovf",  ALU_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
      run_op("removf",  ALU_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 0);
      run_op("remu0",   ALU_REMU, 32'd5,        32'd0,        32'd5,        1, 0);

      // Flush at N+10 of a DIV: idle at N+11, no done, result still 5; restart accepted at N+11
      alu_sel = ALU_DIV; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check_eq("flush_pre_busy", {31'b0, busy}, 32'd1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check_eq("flush_busy", {31'b0, busy}, 32'd0);
      check_eq("flush_done", {31'b0, done}, 32'd0);
      check_eq("flush_result", result, 32'd5);
      run_op("flush_restart", ALU_DIVU, 32'd100, 32'd7, 32'd14, 34, 33);

      // Reset at N+5 of a DIVU
      alu_sel = ALU_DIVU; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_eq("midrst_result", result, 32'd0);
      check_eq("midrst_busy", {31'b0, busy}, 32'd0);
      check_eq("midrst_done", {31'b0, done}, 32'd0);

      // Non-M selection ignored
      alu_sel = ALU_ADD; op_a = 32'd1; op_b = 32'd2; start = 1'b1;
      @(posedge clk); #1;
      check_eq("nonm_busy1", {31'b0, busy}, 32'd0);
      check_eq("nonm_done1", {31'b0, done}, 32'd0);
      start = 1'b0;
      @(posedge clk); #1;
      check_eq("nonm_done2", {31'b0, done}, 32'd0);

      // Flush together with start in IDLE: flush wins
      alu_sel = ALU_DIV; op_a = 32'd9; op_b = 32'd0; start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      check_eq("flushstart_done", {31'b0, done}, 32'd0);
      check_eq("flushstart_busy", {31'b0, busy}, 32'd0);
      check_eq("flushstart_result", result, 32'd0);

      // Start held through DONE is ignored there, accepted the cycle after
      alu_sel = ALU_DIV; op_a = 32'd5; op_b = 32'd0; start = 1'b1;
      @(posedge clk); #1;
      check_eq("dn_done1", {31'b0, done}, 32'd1);
      check_eq("dn_res1", result, 32'hFFFFFFFF);
      alu_sel = ALU_REMU; op_a = 32'd9;
      @(posedge clk); #1;
      check_eq("dn_ignored_done", {31'b0, done}, 32'd0);
      check_eq("dn_ignored_res", result, 32'hFFFFFFFF);
      @(posedge clk); #1;
      start = 1'b0;
      check_eq("dn_next_done", {31'b0, done}, 32'd1);
      check_eq("dn_next_res", result, 32'd9);
      @(posedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
